// File: rtl/kmap_sweep_checker.sv
// rtl/kmap_sweep_checker.sv - sweeps x over all 2**W codes, captures f and checks it against a cared expected table
module kmap_sweep_checker #(
   parameter int W      = 4,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2**W-1:0]   expect_val,
   input  logic [2**W-1:0]   care_mask,
   output logic [W-1:0]      x_out,
   input  logic              f_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [2**W-1:0]   captured,
   output logic              fail_valid,
   output logic [W-1:0]      first_fail
);

   localparam int N = 2**W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t         state, state_nx;
   logic [N-1:0]   exp_q, care_q;
   logic [3:0]     cnt;
   logic           launch;
   logic           mismatch;
   logic           last;

   assign mismatch = care_q[x_out] && (f_in !== exp_q[x_out]);
   assign last     = (x_out == W'(N - 1));
   assign busy     = (state == S_SETTLE) || (state == S_SAMPLE);
   assign done     = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // A start still held during DONE launches the next sweep directly,
   // so back-to-back sweeps need no idle cycle between them.
   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               launch   = 1'b1;
               state_nx = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_SETTLE: begin
            if (cnt == 4'(SETTLE - 1)) state_nx = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (last)              state_nx = S_DONE;
            else if (SETTLE == 0)  state_nx = S_SAMPLE;
            else                   state_nx = S_SETTLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exp_q      <= '0;
         care_q     <= '0;
         cnt        <= '0;
         x_out      <= '0;
         pass       <= 1'b0;
         captured   <= '0;
         fail_valid <= 1'b0;
         first_fail <= '0;
      end else if (launch) begin
         exp_q      <= expect_val;
         care_q     <= care_mask;
         cnt        <= '0;
         x_out      <= '0;
         pass       <= 1'b0;
         captured   <= '0;
         fail_valid <= 1'b0;
         first_fail <= '0;
      end else begin
         case (state)
            S_SETTLE: cnt <= cnt + 4'd1;
            S_SAMPLE: begin
               cnt             <= '0;
               captured[x_out] <= f_in;
               if (mismatch && !fail_valid) begin
                  fail_valid <= 1'b1;
                  first_fail <= x_out;
               end
               // pass is resolved here so it is already valid during DONE
               if (last) pass  <= ~(fail_valid | mismatch);
               else      x_out <= x_out + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
